// File: rtl/sync_fifo_ext_if.sv
// rtl/sync_fifo_ext_if.sv - write/read/status bundle of the extended single-clock FIFO
interface sync_fifo_ext_if #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 10
);
   localparam int CW = $clog2(DEPTH + 1);

   logic             wr_en;
   logic [WIDTH-1:0] data_in;
   logic             rd_en;
   logic [WIDTH-1:0] data_out;
   logic             full;
   logic             empty;
   logic             almost_full;
   logic             almost_empty;
   logic [CW-1:0]    count;
   logic             overflow;
   logic             underflow;

   modport master (
      output wr_en, data_in, rd_en,
      input  data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
   );

   modport slave (
      input  wr_en, data_in, rd_en,
      output data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
   );
endinterface

// File: rtl/sync_fifo_ext.sv
// rtl/sync_fifo_ext.sv - single-clock FIFO, arbitrary depth, thresholds, error pulses, optional FWFT
module sync_fifo_ext #(
   parameter int WIDTH    = 16,
   parameter int DEPTH    = 10,
   parameter int FWFT     = 0,
   parameter int AF_LEVEL = DEPTH - 2,
   parameter int AE_LEVEL = 2
) (
   input logic         clk,
   input logic         rst,
   sync_fifo_ext_if.slave bus
);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = $clog2(DEPTH);

   generate
      if (DEPTH < 2 || AE_LEVEL < 0 || AE_LEVEL >= AF_LEVEL || AF_LEVEL > DEPTH) begin : g_bad_params
         $error("sync_fifo_ext: illegal DEPTH/AE_LEVEL/AF_LEVEL combination");
      end
   endgenerate

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [CW-1:0]    cnt_q;
   logic [CW-1:0]    cnt_d;
   logic             full_q;
   logic             empty_q;
   logic             af_q;
   logic             ae_q;
   logic             ovf_q;
   logic             unf_q;
   logic             wr_acc;
   logic             rd_acc;

   // Acceptance uses the registered flags, i.e. the state before this edge.
   assign wr_acc = bus.wr_en & ~full_q;
   assign rd_acc = bus.rd_en & ~empty_q;

   always_comb begin
      cnt_d = cnt_q;
      if (wr_acc && !rd_acc) begin
         cnt_d = cnt_q + CW'(1);
      end else if (rd_acc && !wr_acc) begin
         cnt_d = cnt_q - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         cnt_q   <= '0;
         full_q  <= 1'b0;
         empty_q <= 1'b1;
         af_q    <= 1'b0;
         ae_q    <= 1'b1;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         if (wr_acc) begin
            wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
         end
         if (rd_acc) begin
            rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
         end
         cnt_q   <= cnt_d;
         full_q  <= (cnt_d == CW'(DEPTH));
         empty_q <= (cnt_d == '0);
         af_q    <= (cnt_d >= CW'(AF_LEVEL));
         ae_q    <= (cnt_d <= CW'(AE_LEVEL));
         ovf_q   <= bus.wr_en & full_q;
         unf_q   <= bus.rd_en & empty_q;
      end
   end

   // Storage is deliberately left out of reset; the pointers alone define validity.
   always_ff @(posedge clk) begin
      if (!rst && wr_acc) begin
         mem[wr_ptr] <= bus.data_in;
      end
   end

   generate
      if (FWFT != 0) begin : g_fwft
         assign bus.data_out = empty_q ? '0 : mem[rd_ptr];
      end else begin : g_std
         logic [WIDTH-1:0] dout_q;
         always_ff @(posedge clk) begin
            if (rst) begin
               dout_q <= '0;
            end else if (rd_acc) begin
               dout_q <= mem[rd_ptr];
            end
         end
         assign bus.data_out = dout_q;
      end
   endgenerate

   assign bus.full         = full_q;
   assign bus.empty        = empty_q;
   assign bus.almost_full  = af_q;
   assign bus.almost_empty = ae_q;
   assign bus.count        = cnt_q;
   assign bus.overflow     = ovf_q;
   assign bus.underflow    = unf_q;
endmodule

// File: tb/tb_sync_fifo_ext.sv
// tb/tb_sync_fifo_ext.sv - scoreboard bench for sync_fifo_ext in standard and FWFT modes
module tb_sync_fifo_ext;
   logic clk = 1'b0;
   logic rst;
   int   tests = 0;
   int   fails = 0;

   always #5 clk = ~clk;

   sync_fifo_ext_if #(.WIDTH(16), .DEPTH(10)) b  ();
   sync_fifo_ext_if #(.WIDTH(16), .DEPTH(10)) fb ();

   sync_fifo_ext #(.WIDTH(16), .DEPTH(10), .FWFT(0)) dut_std (.clk(clk), .rst(rst), .bus(b.slave));
   sync_fifo_ext #(.WIDTH(16), .DEPTH(10), .FWFT(1)) dut_fw  (.clk(clk), .rst(rst), .bus(fb.slave));

   logic [15:0] mq [$];
   logic [15:0] exp_q [$];

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Standard-mode monitor: a read seen accepted before an edge must show its word after it.
   initial begin : monitor
      logic pend;
      logic [15:0] e;
      pend = 1'b0;
      forever begin
         @(negedge clk);
         if (pend) begin
            if (exp_q.size() == 0) begin
               chk("sb_unexpected_read", 1, 0);
            end else begin
               e = exp_q.pop_front();
               chk("sb_data_out", int'(b.data_out), int'(e));
            end
         end
         pend = b.rd_en && !b.empty && !rst;
      end
   end

   task automatic check_flags(input logic ov, input logic un);
      int c;
      c = mq.size();
      chk("count", int'(b.count), c);
      chk("full", int'(b.full), int'(c == 10));
      chk("empty", int'(b.empty), int'(c == 0));
      chk("almost_full", int'(b.almost_full), int'(c >= 8));
      chk("almost_empty", int'(b.almost_empty), int'(c <= 2));
      chk("overflow", int'(b.overflow), int'(ov));
      chk("underflow", int'(b.underflow), int'(un));
   endtask

   task automatic cyc(input logic w, input logic [15:0] d, input logic r);
      logic m_full, m_empty, ov, un;
      b.wr_en = w;
      b.data_in = d;
      b.rd_en = r;
      @(posedge clk);
      m_full  = (mq.size() == 10);
      m_empty = (mq.size() == 0);
      ov = w && m_full;
      un = r && m_empty;
      if (r && !m_empty) exp_q.push_back(mq.pop_front());
      if (w && !m_full) mq.push_back(d);
      #1;
      check_flags(ov, un);
      b.wr_en = 1'b0;
      b.rd_en = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      mq.delete();
      check_flags(1'b0, 1'b0);
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish, tests %0d failed %0d", tests, fails);
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      b.wr_en = 1'b0; b.rd_en = 1'b0; b.data_in = '0;
      fb.wr_en = 1'b0; fb.rd_en = 1'b0; fb.data_in = '0;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      check_flags(1'b0, 1'b0);
      chk("reset_data_out", int'(b.data_out), 0);

      // Fill past full: almost_full at 8, overflow on the extra five.
      for (int i = 1; i <= 10; i++) cyc(1'b1, 16'(i), 1'b0);
      for (int i = 0; i < 5; i++) cyc(1'b1, 16'h00FF, 1'b0);

      // Drain past empty: three underflows, data_out holds the last word.
      for (int i = 0; i < 13; i++) cyc(1'b0, 16'h0, 1'b1);
      @(negedge clk);
      chk("hold_after_underflow", int'(b.data_out), 16'h000A);

      // Wrap-around across the 9 -> 0 pointer boundary.
      for (int i = 0; i < 7; i++) cyc(1'b1, 16'h0200 + 16'(i), 1'b0);
      for (int i = 0; i < 7; i++) cyc(1'b0, 16'h0, 1'b1);
      for (int i = 0; i < 10; i++) cyc(1'b1, 16'h0300 + 16'(i), 1'b0);
      for (int i = 0; i < 10; i++) cyc(1'b0, 16'h0, 1'b1);

      // Simultaneous traffic at mid, full and empty occupancy.
      for (int i = 0; i < 5; i++) cyc(1'b1, 16'h0400 + 16'(i), 1'b0);
      for (int i = 0; i < 20; i++) cyc(1'b1, 16'h0500 + 16'(i), 1'b1);
      for (int i = 0; i < 5; i++) cyc(1'b1, 16'h0600 + 16'(i), 1'b0);
      cyc(1'b1, 16'h0700, 1'b1);
      for (int i = 0; i < 9; i++) cyc(1'b0, 16'h0, 1'b1);
      cyc(1'b1, 16'h0800, 1'b1);
      cyc(1'b0, 16'h0, 1'b1);

      // Mid-stream reset discards contents.
      for (int i = 0; i < 6; i++) cyc(1'b1, 16'h0900 + 16'(i), 1'b0);
      @(negedge clk);
      do_reset();
      chk("reset_mid_data_out", int'(b.data_out), 0);
      cyc(1'b1, 16'hBEEF, 1'b0);
      cyc(1'b0, 16'h0, 1'b1);
      @(negedge clk);
      chk("after_reset_word", int'(b.data_out), 16'hBEEF);

      // FWFT instance: word visible without rd_en, pop presents next.
      fb.data_in = 16'h1234; fb.wr_en = 1'b1;
      @(posedge clk); #1;
      fb.wr_en = 1'b0;
      chk("fwft_empty", int'(fb.empty), 0);
      chk("fwft_first_word", int'(fb.data_out), 16'h1234);
      fb.data_in = 16'h5678; fb.wr_en = 1'b1;
      @(posedge clk); #1;
      fb.wr_en = 1'b0;
      chk("fwft_count2", int'(fb.count), 2);
      chk("fwft_head_kept", int'(fb.data_out), 16'h1234);
      fb.rd_en = 1'b1;
      @(posedge clk); #1;
      fb.rd_en = 1'b0;
      chk("fwft_second_word", int'(fb.data_out), 16'h5678);
      chk("fwft_count1", int'(fb.count), 1);

      repeat (2) @(posedge clk);
      #1;
      chk("sb_drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/sync_fifo_ext.md
Name: sync_fifo_ext

Overview:
Parametrised successor to the team's single-clock FIFO. It adds arbitrary (non-power-of-two) depth and programmable almost-full/almost-empty thresholds. It also adds an occupancy count, overflow/underflow error pulses, and a selectable standard or first-word-fall-through (FWFT) read mode. Intended as the common buffering primitive between producer/consumer blocks in one clock domain.

Parameters:
WIDTH, 16, data word width in bits (>=1)
DEPTH, 10, number of storage entries (>=2, need not be a power of two)
FWFT, 0, read mode: 0 = standard (registered read, data one cycle after rd_en); 1 = first-word-fall-through
AF_LEVEL, DEPTH-2, almost_full asserts when count >= AF_LEVEL
AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL
CW, $clog2(DEPTH+1), derived count width (localparam, not overridable)

Ports:
clk  input  1  clock; all state changes on rising edge
rst  input  1  synchronous, active-high reset
wr_en  input  1  write request
data_in  input  WIDTH  write data, sampled with wr_en
rd_en  input  1  read request / pop
data_out  output  WIDTH  read data
full  output  1  count == DEPTH
empty  output  1  count == 0
almost_full  output  1  count >= AF_LEVEL
almost_empty  output  1  count <= AE_LEVEL
count  output  CW  current occupancy, 0..DEPTH
overflow  output  1  one-cycle pulse: write rejected
underflow  output  1  one-cycle pulse: read rejected

Behaviour:
- Reset (rst=1 at a rising edge), regardless of other inputs:
  - wr_ptr=0, rd_ptr=0, count=0.
  - empty=1, full=0, almost_empty=1, almost_full=0, overflow=0, underflow=0, data_out=0.
  - Memory array is not cleared.
  - Reset mid-operation discards all stored words.
- Acceptance: write accepted = wr_en & !full; read accepted = rd_en & !empty. Both use flag values before the edge.
- Full with wr_en and rd_en together: read accepted, write rejected, overflow pulses, count decrements.
- Empty with wr_en and rd_en together: write accepted, read rejected, underflow pulses, count becomes 1.
- Accepted write: mem[wr_ptr] <= data_in; wr_ptr advances, wrapping DEPTH-1 -> 0.
- Accepted read: rd_ptr advances with the same wrap rule.
- Count update: +1 on write only, -1 on read only, unchanged when both or neither are accepted.
- Flags: all registered and derived from next-count. They change on the same edge as count, with no extra cycle of lag.
- Standard mode (FWFT=0):
  - On an accepted read, data_out <= mem[rd_ptr]. The value is valid the cycle after the rd_en edge.
  - data_out holds its last value when no read is accepted, including on rejected reads.
- FWFT mode (FWFT=1):
  - data_out presents mem[rd_ptr] whenever empty=0. The first word is visible the cycle after its write edge, with no rd_en needed.
  - rd_en pops the word; the next word is presented on the following cycle.
  - data_out is don't-care while empty=1.
- overflow: registered, high for exactly the one cycle following each edge where wr_en=1 and full=1. Pointers and memory are unchanged.
- underflow: same rule for rd_en=1 and empty=1.
- Legality checks: elaboration must fail unless DEPTH>=2 and 0<=AE_LEVEL<AF_LEVEL<=DEPTH.

Test Plan:
1. Fill (WIDTH=16, DEPTH=10, FWFT=0): after reset, write 0x0001..0x000A, then 5 more writes of 0x00FF.
   -> almost_full rises with count=8; full=1 and count=10 after the 10th write; overflow pulses on 5 consecutive cycles; contents unchanged.
2. Drain: 13 consecutive reads.
   -> data_out shows 0x0001..0x000A, each one cycle after its rd_en edge; almost_empty rises at count=2; empty=1 after the 10th read; underflow pulses 3 times; data_out holds 0x000A.
3. Wrap-around: write 7, read 7, write 10, read 10 (pointers cross 9 -> 0).
   -> all 17 words return in write order; full asserts only at count=10.
4. Simultaneous operations:
   - At count=5, wr_en=rd_en=1 for 20 cycles -> count stays 5, output order preserved.
   - At count=10, wr+rd -> count=9, overflow=1.
   - At count=0, wr+rd -> count=1, underflow=1.
5. FWFT=1 instance: write 0x1234 into empty FIFO.
   -> next cycle empty=0 and data_out=0x1234 without rd_en; write 0x5678, pulse rd_en -> data_out=0x5678 the next cycle, count=1.
6. Reset at count=6 mid-stream.
   -> after the rst edge: count=0, empty=1, all flags at reset values; then write 0xBEEF, read -> 0xBEEF (no stale data).
